riscv_wb_tracer: RTL and testbench

Synthesizable successor to the processor bench harness: captures the core's writeback stream into a parametrised trace buffer and bounds the run with a cycle budget. It sits beside the riscv core, snooping its writeback bus. After the run ends it raises done and lets a host or bench drain the captured values in order. Buffer depth, data width, run length and overflow mode are parameters.

---
 rtl/riscv_trace_pkg.sv | 16 +
 rtl/trace_ram.sv | 37 +++
 rtl/riscv_wb_tracer.sv | 150 +++++++++++++++
 tb/tb_riscv_wb_tracer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_trace_pkg.sv
// rtl/riscv_trace_pkg.sv - shared types, defaults and helpers for the writeback tracer
package riscv_trace_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } tracer_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x DATA_W trace storage, one synchronous write port, one registered read port
module trace_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value between pops so rd_data stays stable on empty pops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_wb_tracer.sv
// rtl/riscv_wb_tracer.sv - writeback trace capture with cycle budget; WB_TRACER_SIGNATURE_EN adds a stream signature
module riscv_wb_tracer
    import riscv_trace_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MAX_CYCLES = 65,
    parameter int WRAP_MODE  = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wb_valid,
    input  logic [DATA_W-1:0]                wb_data,
    input  logic                             halt,
    input  logic                             rd_en,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             rd_valid,
    output logic                             done,
    output logic                             empty,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             overflow,
`ifdef WB_TRACER_SIGNATURE_EN
    output logic [DATA_W-1:0]                sig,
`endif
    output logic [$clog2(MAX_CYCLES+1)-1:0]  cycle_cnt
);

    localparam int PW  = ptr_width(DEPTH);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CCW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [CCW-1:0] LAST_CYC = CCW'(MAX_CYCLES - 1);

    tracer_state_e   state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CCW-1:0]  cyc_q, cyc_d;
    logic            ovf_q, ovf_d;
    logic            rd_valid_q, rd_valid_d;
    logic            done_q, done_d;
    logic            ram_we, ram_re;
    logic            full;

    assign full = (count_q == FULL_CNT);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cyc_d      = cyc_q;
        ovf_d      = ovf_q;
        rd_valid_d = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        if (state_q == ST_RUN) begin
            if (wb_valid) begin
                if (!full) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = count_q + CW'(1);
                end else if (WRAP_MODE != 0) begin
                    // Overwrite the oldest slot; the read pointer skips past it.
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    ovf_d    = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if ((cyc_q == LAST_CYC) || halt) begin
                state_d = ST_DONE;
            end else begin
                cyc_d = cyc_q + CCW'(1);
            end
        end else begin
            if (rd_en && (count_q != '0)) begin
                ram_re     = 1'b1;
                rd_ptr_d   = rd_ptr_q + PW'(1);
                count_d    = count_q - CW'(1);
                rd_valid_d = 1'b1;
            end
        end

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cyc_q      <= cyc_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    trace_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PW)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wb_data),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

`ifdef WB_TRACER_SIGNATURE_EN
    logic [DATA_W-1:0] sig_q;

    // Dropped entries still fold in, so the signature reflects the full stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= '0;
        end else if ((state_q == ST_RUN) && wb_valid) begin
            sig_q <= {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ wb_data;
        end
    end

    assign sig = sig_q;
`endif

    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_riscv_wb_tracer.sv
// tb/tb_riscv_wb_tracer.sv - randomized self-checking bench for three tracer configurations
module tb_riscv_wb_tracer;

    localparam int N    = 3;
    localparam int MAXC = 65;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        halt;
    logic        rd_en;
    logic [31:0] wb_data;

    logic [31:0] rd_data_w [N];
    logic        rd_valid_w [N];
    logic        done_w [N];
    logic        empty_w [N];
    logic        ovf_w [N];
    logic [6:0]  cyc_w [N];
    logic [4:0]  cnt0;
    logic [2:0]  cnt1;
    logic [2:0]  cnt2;
    logic [4:0]  cnt_w [N];
`ifdef WB_TRACER_SIGNATURE_EN
    logic [31:0] sig_w [N];
`endif

    assign cnt_w[0] = cnt0;
    assign cnt_w[1] = {2'b00, cnt1};
    assign cnt_w[2] = {2'b00, cnt2};

    always #5 clk = ~clk;

    riscv_wb_tracer #(.DATA_W(32), .DEPTH(16), .MAX_CYCLES(MAXC), .WRAP_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_data(wb_data), .halt(halt),
        .rd_en(rd_en), .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .done(done_w[0]),
        .empty(empty_w[0]), .count(cnt0), .overflow(ovf_w[0]),
`ifdef WB_TRACER_SIGNATURE_EN
        .sig(sig_w[0]),
`endif
        .cycle_cnt(cyc_w[0]));

    riscv_wb_tracer #(.DATA_W(32), .DEPTH(4), .MAX_CYCLES(MAXC), .WRAP_MODE(0)) dut1 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_data(wb_data), .halt(halt),
        .rd_en(rd_en), .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .done(done_w[1]),
        .empty(empty_w[1]), .count(cnt1), .overflow(ovf_w[1]),
`ifdef WB_TRACER_SIGNATURE_EN
        .sig(sig_w[1]),
`endif
        .cycle_cnt(cyc_w[1]));

    riscv_wb_tracer #(.DATA_W(32), .DEPTH(4), .MAX_CYCLES(MAXC), .WRAP_MODE(1)) dut2 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_data(wb_data), .halt(halt),
        .rd_en(rd_en), .rd_data(rd_data_w[2]), .rd_valid(rd_valid_w[2]), .done(done_w[2]),
        .empty(empty_w[2]), .count(cnt2), .overflow(ovf_w[2]),
`ifdef WB_TRACER_SIGNATURE_EN
        .sig(sig_w[2]),
`endif
        .cycle_cnt(cyc_w[2]));

    int          total = 0;
    int          bad   = 0;
    int          depth_m [N] = '{16, 4, 4};
    int          wrap_m  [N] = '{0, 0, 1};
    logic [31:0] q_m [N][$];
    bit          done_m [N];
    bit          ovf_m  [N];
    bit          rv_m   [N];
    logic [31:0] rd_m   [N];
    logic [31:0] sig_m  [N];
    int          run_m  [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            q_m[i].delete();
            done_m[i] = 1'b0;
            ovf_m[i]  = 1'b0;
            rv_m[i]   = 1'b0;
            rd_m[i]   = '0;
            sig_m[i]  = '0;
            run_m[i]  = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            rv_m[i] = 1'b0;
            if (!done_m[i]) begin
                if (wb_valid) begin
                    sig_m[i] = {sig_m[i][30:0], sig_m[i][31]} ^ wb_data;
                    if (q_m[i].size() < depth_m[i]) begin
                        q_m[i].push_back(wb_data);
                    end else begin
                        ovf_m[i] = 1'b1;
                        if (wrap_m[i] != 0) begin
                            void'(q_m[i].pop_front());
                            q_m[i].push_back(wb_data);
                        end
                    end
                end
                if (run_m[i] == MAXC - 1 || halt) done_m[i] = 1'b1;
                else run_m[i]++;
            end else if (rd_en && q_m[i].size() > 0) begin
                rd_m[i] = q_m[i].pop_front();
                rv_m[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("count%0d", i), 64'(cnt_w[i]), 64'(q_m[i].size()));
            check($sformatf("empty%0d", i), 64'(empty_w[i]), 64'(q_m[i].size() == 0));
            check($sformatf("done%0d", i), 64'(done_w[i]), 64'(done_m[i]));
            check($sformatf("overflow%0d", i), 64'(ovf_w[i]), 64'(ovf_m[i]));
            check($sformatf("rd_valid%0d", i), 64'(rd_valid_w[i]), 64'(rv_m[i]));
            check($sformatf("rd_data%0d", i), 64'(rd_data_w[i]), 64'(rd_m[i]));
            check($sformatf("cycle_cnt%0d", i), 64'(cyc_w[i]), 64'(run_m[i]));
`ifdef WB_TRACER_SIGNATURE_EN
            check($sformatf("sig%0d", i), 64'(sig_w[i]), 64'(sig_m[i]));
`endif
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic h, input logic r);
        wb_valid = v;
        wb_data  = d;
        halt     = h;
        rd_en    = r;
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    // Assert mid-cycle so the immediate check exercises the asynchronous path.
    task automatic do_reset();
        reset    = 1'b0;
        wb_valid = 1'b0;
        halt     = 1'b0;
        rd_en    = 1'b0;
        wb_data  = '0;
        #2;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        wb_valid = 1'b0;
        halt     = 1'b0;
        rd_en    = 1'b0;
        wb_data  = '0;
        @(posedge clk);
        #1;

        do_reset();
        for (int c = 0; c < MAXC + 3; c++) step(1'b0, 32'h0, 1'b0, 1'b0);
        check("idle_cycle_cnt", 64'(cyc_w[0]), 64'(MAXC - 1));

        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 32'h11 + 32'(k), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b0, 1'b1);
        check("sixth_pop_data", 64'(rd_data_w[0]), 64'h15);

        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 32'(k + 1), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 1'b0, 1'b1);

        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 32'h11 + 32'(k), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, 32'h0, 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 32'hA0 + 32'(k), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b0, 1'b1);

        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int c = 0; c < MAXC + 2; c++)
                step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 24; c++)
                step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
